// File: rtl/seg_pkg.sv
// Shared constants and the frame record for the 6-digit 7-segment scan controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

   localparam int NUM_DIG = 6;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef struct packed {
      logic [4*NUM_DIG-1:0] bcd;
      logic [NUM_DIG-1:0]   dp;
      logic                 blank_lz;
   } frame_t;

   // Power-up frame shows a single "0" (leading zeros blanked).
   localparam frame_t FRAME_RST = '{bcd: '0, dp: '0, blank_lz: 1'b1};

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD nibble to active-low segment pattern; non-decimal nibbles show a dash.
module seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      // NOTE: assigning a default before the case keeps this block free of inferred latches.
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      if (dp) seg[7] = 1'b0;
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 6-digit multiplexed 7-segment scan scheduler: double-buffered frame input,
// per-slot dead gap, PWM brightness and leading-zero blanking; outputs registered.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGIT_CYC = 50_000,
   parameter int DEAD_CYC  = 500
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic [4*NUM_DIG-1:0] din_bcd,
   input  logic [NUM_DIG-1:0]   din_dp,
   input  logic                 din_blank_lz,
   input  logic [2:0]           bright,
   output logic                 frame_done,
   output logic [NUM_DIG-1:0]   sel,
   output logic [7:0]           seg_dig
);

   localparam int SLICE = (DIGIT_CYC - DEAD_CYC) / 8;
   localparam int CNT_W = $clog2(DIGIT_CYC);
   localparam int IDX_W = $clog2(NUM_DIG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

   logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]   dig_idx_q, dig_idx_d;
   logic [2:0]         bright_q, bright_d;
   logic               pend_full_q, pend_full_d;
   frame_t             pend_q, pend_d;
   frame_t             act_q, act_d;
   logic [NUM_DIG-1:0] sel_q, sel_d;
   logic [7:0]         seg_q, seg_d;

   logic               frame_end;
   logic [31:0]        slot_ext, lit_end;
   logic               lit;
   logic               zero_run;
   logic [NUM_DIG-1:0] blank_mask;
   logic [3:0]         cur_nib;
   logic               cur_dp;
   logic [7:0]         dec_seg, glyph;

   // Slot/digit counters, brightness capture and the pending/active frame buffers.
   always_comb begin
      slot_cnt_d  = slot_cnt_q + 1'b1;
      dig_idx_d   = dig_idx_q;
      frame_end   = (dig_idx_q == IDX_LAST) && (slot_cnt_q == CNT_LAST);
      if (slot_cnt_q == CNT_LAST) begin
         slot_cnt_d = '0;
         dig_idx_d  = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
      end

      // Brightness is taken live in the slot's first cycle so that cycle already uses it.
      bright_d = (slot_cnt_q == '0) ? bright : bright_q;

      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      act_d       = act_q;
      if (frame_end && pend_full_q) begin
         act_d       = pend_q;
         pend_full_d = 1'b0;
      end else if (din_valid && !pend_full_q) begin
         pend_d      = '{bcd: din_bcd, dp: din_dp, blank_lz: din_blank_lz};
         pend_full_d = 1'b1;
      end
   end

   // PWM window: dead gap first, then SLICE cycles per brightness step.
   always_comb begin
      slot_ext = 32'(slot_cnt_q);
      lit_end  = 32'(DEAD_CYC) + 32'(SLICE) * (32'(bright_d) + 32'd1);
      lit      = (slot_ext >= 32'(DEAD_CYC)) && (slot_ext < lit_end);
   end

   // A digit is blanked while it and every digit above it are zero; digit0 always shows.
   always_comb begin
      zero_run   = 1'b1;
      blank_mask = '0;
      for (int k = NUM_DIG - 1; k >= 1; k--) begin
         zero_run      = zero_run && (act_q.bcd[4*k +: 4] == 4'd0);
         blank_mask[k] = act_q.blank_lz && zero_run;
      end
   end

   assign cur_nib = act_q.bcd[{dig_idx_q, 2'b00} +: 4];
   assign cur_dp  = act_q.dp[dig_idx_q];

   seg_decoder u_dec (
      .bcd (cur_nib),
      .dp  (cur_dp),
      .seg (dec_seg)
   );

   always_comb begin
      glyph = blank_mask[dig_idx_q] ? {~cur_dp, 7'h7F} : dec_seg;
      sel_d = '1;
      seg_d = SEG_BLANK;
      if (lit) begin
         sel_d = ~(NUM_DIG'(1) << dig_idx_q);
         seg_d = glyph;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_cnt_q  <= '0;
         dig_idx_q   <= '0;
         bright_q    <= '0;
         pend_full_q <= 1'b0;
         // NOTE: the pending payload is reset too, so nothing undefined can ever be swapped into view.
         pend_q      <= FRAME_RST;
         act_q       <= FRAME_RST;
         sel_q       <= '1;
         seg_q       <= SEG_BLANK;
      end else begin
         // NOTE: non-blocking updates make every flop sample the pre-edge values together.
         slot_cnt_q  <= slot_cnt_d;
         dig_idx_q   <= dig_idx_d;
         bright_q    <= bright_d;
         pend_full_q <= pend_full_d;
         pend_q      <= pend_d;
         act_q       <= act_d;
         sel_q       <= sel_d;
         seg_q       <= seg_d;
      end
   end

   assign din_ready  = ~pend_full_q;
   assign frame_done = frame_end;
   assign sel        = sel_q;
   assign seg_dig    = seg_q;

endmodule
